// File: rtl/quad_pkg.sv
// ============================================================================
// quad_pkg : shared types, Gray phase constants and step decode for quad_decoder
// Revision : 1.0
// ============================================================================
`default_nettype none

package quad_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      TRACK = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      MV_NONE    = 2'd0,
      MV_UP      = 2'd1,
      MV_DN      = 2'd2,
      MV_ILLEGAL = 2'd3
   } move_e;

   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_01 = 2'b01;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_10 = 2'b10;

   function automatic logic [1:0] next_up(input logic [1:0] ph);
      logic [1:0] nx;
      case (ph)
         PH_00:   nx = PH_01;
         PH_01:   nx = PH_11;
         PH_11:   nx = PH_10;
         default: nx = PH_00;
      endcase
      return nx;
   endfunction

   // A single-bit change that is not the forward neighbour must be the reverse one.
   function automatic move_e decode_move(input logic [1:0] prev, input logic [1:0] cur);
      move_e mv;
      if (prev == cur)
         mv = MV_NONE;
      else if ((prev ^ cur) == 2'b11)
         mv = MV_ILLEGAL;
      else if (next_up(prev) == cur)
         mv = MV_UP;
      else
         mv = MV_DN;
      return mv;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// ============================================================================
// sync_ff : 1-bit multi-flop synchronizer with synchronous clear
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o,
   output logic q_next_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst)
         sync_q <= '0;
      else
         sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o      = sync_q[STAGES-1];
   // Value q_o will hold after the next edge; lets a consumer seed history without a stale sample.
   assign q_next_o = sync_q[STAGES-2];

endmodule

`default_nettype wire

// File: rtl/quad_decoder.sv
// ============================================================================
// quad_decoder : quadrature position counter with preset, direction, step
//                pulse and sticky illegal-transition flag.
//                Optional index zeroing enabled by macro QUAD_INDEX_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module quad_decoder
   import quad_pkg::*;
#(
   parameter int N           = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         preset,
   input  logic [N-1:0] d_in,
   input  logic         a_in,
   input  logic         b_in,
`ifdef QUAD_INDEX_EN
   input  logic         index_in,
`endif
   output logic [N-1:0] d_out,
   output logic         dir,
   output logic         step,
   output logic         err
);

   localparam logic [1:0] INIT_LAST = 2'(SYNC_STAGES - 1);

   logic         a_s, b_s, a_n, b_n;
   logic [1:0]   ab_s, ab_n;
   move_e        mv;
   logic         idx_hit;

   state_e       state_q, state_d;
   logic [1:0]   init_cnt_q, init_cnt_d;
   logic [1:0]   prev_q, prev_d;
   logic [N-1:0] cnt_q, cnt_d;
   logic         dir_q, dir_d;
   logic         step_q, step_d;
   logic         err_q, err_d;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (
      .clk      (clk),
      .rst      (clear),
      .d_i      (a_in),
      .q_o      (a_s),
      .q_next_o (a_n)
   );

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (
      .clk      (clk),
      .rst      (clear),
      .d_i      (b_in),
      .q_o      (b_s),
      .q_next_o (b_n)
   );

   assign ab_s = {a_s, b_s};
   assign ab_n = {a_n, b_n};
   assign mv   = decode_move(prev_q, ab_s);

`ifdef QUAD_INDEX_EN
   logic idx_s, idx_n, idx_prev_q;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_idx (
      .clk      (clk),
      .rst      (clear),
      .d_i      (index_in),
      .q_o      (idx_s),
      .q_next_o (idx_n)
   );

   // Seeded at INIT exit so an index held high through clear is not seen as an edge.
   always_ff @(posedge clk) begin
      if (clear)
         idx_prev_q <= 1'b0;
      else if (state_q == INIT && init_cnt_q == INIT_LAST)
         idx_prev_q <= idx_n;
      else
         idx_prev_q <= idx_s;
   end

   assign idx_hit = (state_q == TRACK) && idx_s && !idx_prev_q && (ab_s == PH_11);
`else
   assign idx_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      prev_d     = prev_q;
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      step_d     = 1'b0;
      err_d      = err_q;

      if (state_q == INIT) begin
         init_cnt_d = init_cnt_q + 2'd1;
         if (init_cnt_q == INIT_LAST) begin
            state_d    = TRACK;
            init_cnt_d = 2'd0;
            prev_d     = ab_n;
         end
      end else begin
         prev_d = ab_s;
         if (mv == MV_ILLEGAL)
            err_d = 1'b1;
      end

      if (preset) begin
         cnt_d = d_in;
      end else if (idx_hit) begin
         cnt_d = '0;
      end else if (state_q == TRACK) begin
         case (mv)
            MV_UP: begin
               cnt_d  = cnt_q + N'(1);
               dir_d  = 1'b1;
               step_d = 1'b1;
            end
            MV_DN: begin
               cnt_d  = cnt_q - N'(1);
               dir_d  = 1'b0;
               step_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q    <= INIT;
         init_cnt_q <= 2'd0;
         prev_q     <= PH_00;
         cnt_q      <= '0;
         dir_q      <= 1'b1;
         step_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         prev_q     <= prev_d;
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
         step_q     <= step_d;
         err_q      <= err_d;
      end
   end

   assign d_out = cnt_q;
   assign dir   = dir_q;
   assign step  = step_q;
   assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_quad_decoder.sv
// ============================================================================
// tb_quad_decoder : scoreboard bench for quad_decoder (N=4, SYNC_STAGES=2)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_quad_decoder;

   logic       clk = 1'b0;
   logic       clear = 1'b1;
   logic       preset = 1'b0;
   logic [3:0] d_in = 4'd0;
   logic       a_in = 1'b0;
   logic       b_in = 1'b0;
`ifdef QUAD_INDEX_EN
   logic       index_in = 1'b0;
`endif
   logic [3:0] d_out;
   logic       dir, step, err;

   typedef struct packed {
      logic [3:0] d;
      logic       dr;
      logic       e;
   } exp_t;

   exp_t  sb_q[$];
   string tag_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    step_cnt = 0;
   int    s0;

   quad_decoder #(.N(4), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .clear    (clear),
      .preset   (preset),
      .d_in     (d_in),
      .a_in     (a_in),
      .b_in     (b_in),
`ifdef QUAD_INDEX_EN
      .index_in (index_in),
`endif
      .d_out    (d_out),
      .dir      (dir),
      .step     (step),
      .err      (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (step === 1'b1) step_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [3:0] d, input logic dr, input logic e);
      exp_t x;
      x.d = d; x.dr = dr; x.e = e;
      sb_q.push_back(x);
      tag_q.push_back(tag);
   endtask

   task automatic sb_pop();
      exp_t  x;
      string t;
      if (sb_q.size() == 0) begin
         check_val("sb_underflow", 32'd0, 32'd1);
      end else begin
         x = sb_q.pop_front();
         t = tag_q.pop_front();
         check_val({t, ".d_out"}, 32'(d_out), 32'(x.d));
         check_val({t, ".dir"},   32'(dir),   32'(x.dr));
         check_val({t, ".err"},   32'(err),   32'(x.e));
      end
   endtask

   // Drive a phase pair, then compare once the synchronizer latency has elapsed.
   task automatic phase(input logic [1:0] ab, input string tag,
                        input logic [3:0] d, input logic dr, input logic e);
      a_in = ab[1];
      b_in = ab[0];
      sb_push(tag, d, dr, e);
      repeat (4) @(posedge clk);
      @(negedge clk);
      sb_pop();
   endtask

   task automatic load(input logic [3:0] v, input string tag, input logic dr, input logic e);
      d_in   = v;
      preset = 1'b1;
      sb_push(tag, v, dr, e);
      @(negedge clk);
      preset = 1'b0;
      sb_pop();
   endtask

   task automatic clear_pulse();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_val("rst.d_out", 32'(d_out), 32'd0);
      check_val("rst.dir",   32'(dir),   32'd1);
      check_val("rst.step",  32'(step),  32'd0);
      check_val("rst.err",   32'(err),   32'd0);
      clear = 1'b0;

      // forward sequence
      phase(2'b00, "init_idle", 4'd0, 1'b1, 1'b0);
      s0 = step_cnt;
      phase(2'b01, "fwd1", 4'd1, 1'b1, 1'b0);
      phase(2'b11, "fwd2", 4'd2, 1'b1, 1'b0);
      phase(2'b10, "fwd3", 4'd3, 1'b1, 1'b0);
      phase(2'b00, "fwd4", 4'd4, 1'b1, 1'b0);
      check_val("fwd.steps", 32'(step_cnt - s0), 32'd4);

      // reverse sequence with underflow wrap
      clear_pulse();
      phase(2'b00, "clr_idle", 4'd0, 1'b1, 1'b0);
      phase(2'b10, "rev1", 4'd15, 1'b0, 1'b0);
      phase(2'b11, "rev2", 4'd14, 1'b0, 1'b0);
      phase(2'b01, "rev3", 4'd13, 1'b0, 1'b0);
      phase(2'b00, "rev4", 4'd12, 1'b0, 1'b0);

      // illegal transition, sticky err through preset
      s0 = step_cnt;
      phase(2'b11, "illegal", 4'd12, 1'b0, 1'b1);
      check_val("illegal.steps", 32'(step_cnt - s0), 32'd0);
      load(4'd5, "preset_keeps_err", 1'b0, 1'b1);
      load(4'd6, "preset6", 1'b0, 1'b1);

      // clear at phase 11: nothing counted during INIT, no spurious err at TRACK entry
      s0 = step_cnt;
      clear_pulse();
      check_val("clr.d_out", 32'(d_out), 32'd0);
      check_val("clr.err",   32'(err),   32'd0);
      check_val("clr.dir",   32'(dir),   32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val($sformatf("init%0d.d_out", i), 32'(d_out), 32'd0);
         check_val($sformatf("init%0d.err", i),   32'(err),   32'd0);
         check_val($sformatf("init%0d.step", i),  32'(step),  32'd0);
      end
      check_val("init.steps", 32'(step_cnt - s0), 32'd0);
      phase(2'b10, "first_after_init", 4'd1, 1'b1, 1'b0);

      // preset coinciding with a decoded forward step
      phase(2'b11, "rev_before_preset", 4'd0, 1'b0, 1'b0);
      s0 = step_cnt;
      a_in = 1'b1;
      b_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      d_in   = 4'd9;
      preset = 1'b1;
      sb_push("preset_wins", 4'd9, 1'b0, 1'b0);
      @(negedge clk);
      preset = 1'b0;
      check_val("preset_wins.step", 32'(step), 32'd0);
      sb_pop();
      @(negedge clk);
      check_val("preset_wins.steps", 32'(step_cnt - s0), 32'd0);
      phase(2'b00, "after_preset", 4'd10, 1'b1, 1'b0);

      // latency and overflow wrap
      load(4'd15, "preset15", 1'b1, 1'b0);
      a_in = 1'b0;
      b_in = 1'b1;
      @(negedge clk);
      check_val("lat_e0.d_out", 32'(d_out), 32'd15);
      @(negedge clk);
      check_val("lat_e1.d_out", 32'(d_out), 32'd15);
      check_val("lat_e1.step",  32'(step),  32'd0);
      @(negedge clk);
      check_val("lat_e2.d_out", 32'(d_out), 32'd0);
      check_val("lat_e2.step",  32'(step),  32'd1);
      check_val("lat_e2.dir",   32'(dir),   32'd1);

`ifdef QUAD_INDEX_EN
      phase(2'b11, "to_11", 4'd1, 1'b1, 1'b0);
      load(4'd7, "preset7", 1'b1, 1'b0);
      index_in = 1'b1;
      @(negedge clk);
      index_in = 1'b0;
      @(negedge clk);
      check_val("idx_e1.d_out", 32'(d_out), 32'd7);
      @(negedge clk);
      check_val("idx_e2.d_out", 32'(d_out), 32'd0);
      check_val("idx_e2.step",  32'(step),  32'd0);
`endif

      check_val("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the position counter width in bits.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the input synchronizer depth (legal range 2..3).
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on the rising edge.
REQ-004 Port clear, input, 1: synchronous, active-high reset.
REQ-005 Port preset, input, 1: synchronous load of d_in into the position.
REQ-006 Port d_in, input, N: the preset value.
REQ-007 Ports a_in and b_in, input, 1 each: asynchronous quadrature phases.
REQ-008 Port index_in, input, 1: asynchronous index mark, present only with QUAD_INDEX_EN.
REQ-009 Port d_out, output, N: the position count.
REQ-010 Port dir, output, 1: direction of the last valid step; 1 = up.
REQ-011 Port step, output, 1: a 1-cycle pulse on each counted step.
REQ-012 Port err, output, 1: sticky illegal-transition flag.

Function
REQ-013 a_in and b_in SHALL pass through SYNC_STAGES flops each; decoding SHALL use only the synchronized pair {A,B}.
REQ-014 FSM states:
- INIT: SHALL last exactly SYNC_STAGES cycles after clear deasserts; on the last cycle it loads prev <= {A,B} and moves to TRACK.
- TRACK: decodes each cycle.
- No counting and no err SHALL occur in INIT.
REQ-015 In TRACK, the transitions prev->{A,B} of 00->01, 01->11, 11->10, 10->00 SHALL increment d_out, set dir=1 and pulse step.
REQ-016 In TRACK, the reverse transitions (00->10, 10->11, 11->01, 01->00) SHALL decrement d_out, set dir=0 and pulse step.
REQ-017 In TRACK, no change SHALL hold d_out, dir and step=0.
REQ-018 In TRACK, a change of both bits in one cycle SHALL set err=1 and leave d_out and dir unchanged, with step=0.
REQ-019 prev SHALL load {A,B} every TRACK cycle, including illegal and preset cycles.
REQ-020 Arithmetic SHALL be modulo 2^N: 2^N-1 + 1 = 0 and 0 - 1 = 2^N-1.
REQ-021 Latency: a phase change stable before rising edge E0 SHALL appear on d_out and step after edge E(SYNC_STAGES), i.e. 3 edges with the default.
REQ-022 Priority SHALL be clear > preset > index (if enabled) > step.
REQ-023 A preset coinciding with a valid transition SHALL load d_in, discard the step (step=0), and leave dir unchanged.
REQ-024 err SHALL be cleared only by clear; preset SHALL NOT clear err.
REQ-025 Preset SHALL be honoured in INIT as well as TRACK.

Reset
REQ-026 clear SHALL force d_out=0, dir=1, step=0, err=0, all synchronizer flops=0, prev=00, state=INIT.
REQ-027 clear asserted mid-stream SHALL abandon the step in progress; after deassertion the block SHALL re-enter INIT and count nothing until INIT completes.

Configuration
REQ-028 Macro QUAD_INDEX_EN:
- Defined: index_in exists and is synchronized like a_in; a rising edge of the synchronized index in TRACK while A=1 and B=1 SHALL set d_out=0, overriding any step that cycle (step=0).
- Undefined: neither the port nor the logic SHALL exist, and behaviour is otherwise identical.

Structure
REQ-029 Package quad_pkg SHALL hold the state enum (INIT, TRACK) and the 2-bit Gray phase constants (PH_00, PH_01, PH_11, PH_10).
REQ-030 Sub-module sync_ff (parameter STAGES, 1 bit wide) SHALL be instantiated once per asynchronous input.

Verification (N=4, SYNC_STAGES=2)
REQ-031 Clear, then {a,b} = 00,01,11,10,00, each held 4 clocks -> d_out 0,1,2,3,4; dir=1; exactly 4 step pulses; err=0.
REQ-032 From d_out=0, {a,b} = 00,10,11,01,00 -> d_out 15,14,13,12; dir=0; no err.
REQ-033 In TRACK with prev=00, drive 11 -> err=1, d_out unchanged, step=0; err stays 1 through a preset and clears only on clear.
REQ-034 preset=1 with d_in=9 in the same cycle a forward step decodes -> d_out=9, step=0; the next forward step -> d_out=10.
REQ-035 With inputs at 11 and d_out=6, pulse clear for 1 cycle -> d_out=0 with no count and no err during the 2 INIT cycles; the first forward step after INIT -> d_out=1.
REQ-036 With QUAD_INDEX_EN, d_out=7 and {a,b}=11, pulse index_in -> d_out=0 three edges later; with the macro undefined, the same bench without index_in passes REQ-031 to REQ-035.
